// File: rtl/slot_pkg.sv
// slot_pkg: shared state encoding, default sizes and saturating-add helper for the slot credit ledger.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

package slot_pkg;

  localparam int unsigned DEF_CREDIT_W = 8;
  localparam int unsigned DEF_LOAD_W   = 5;
  localparam int unsigned DEF_BET_W    = 3;
  localparam int unsigned DEF_MULT_W   = 2;
  localparam int unsigned DEF_TIMEOUT  = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Unsigned add clamped to 2^out_w-1; operands are zero-extended to 32 bits by the caller.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned out_w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << out_w) - 33'd1;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/slot_credit_ctrl_if.sv
// slot_credit_ctrl_if: board/reel-side signal bundle of the credit ledger.
// Rev 1.0 -- jackpot member exists only with SLOT_CREDIT_JACKPOT_EN.
`timescale 1ns/1ps
`default_nettype none

interface slot_credit_ctrl_if
  import slot_pkg::*;
#(
  parameter int unsigned CREDIT_W = DEF_CREDIT_W,
  parameter int unsigned LOAD_W   = DEF_LOAD_W,
  parameter int unsigned BET_W    = DEF_BET_W,
  parameter int unsigned MULT_W   = DEF_MULT_W
);
  logic                load_en;
  logic [LOAD_W-1:0]   load_value;
  logic                start;
  logic [BET_W-1:0]    bet;
  logic                spin_req;
  logic                spin_done;
  logic [MULT_W-1:0]   win_mult;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                round_done;
  logic [CREDIT_W:0]   payout;
  logic                err_bet;
`ifdef SLOT_CREDIT_JACKPOT_EN
  logic [CREDIT_W-1:0] jackpot;
`endif

  modport master (
    output load_en, load_value, start, bet, spin_done, win_mult,
`ifdef SLOT_CREDIT_JACKPOT_EN
    input  jackpot,
`endif
    input  spin_req, credit, busy, round_done, payout, err_bet
  );

  modport slave (
    input  load_en, load_value, start, bet, spin_done, win_mult,
`ifdef SLOT_CREDIT_JACKPOT_EN
    output jackpot,
`endif
    output spin_req, credit, busy, round_done, payout, err_bet
  );

endinterface

`default_nettype wire

// File: rtl/sat_adder.sv
// sat_adder: unsigned add of two IN_W operands, clamped to the OUT_W maximum.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module sat_adder
  import slot_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  a_i,
  input  logic [IN_W-1:0]  b_i,
  output logic [OUT_W-1:0] sum_o
);

  assign sum_o = OUT_W'(sat_add(32'(a_i), 32'(b_i), OUT_W));

endmodule

`default_nettype wire

// File: rtl/slot_credit_ctrl.sv
// slot_credit_ctrl: credit ledger and IDLE/SPIN/SETTLE round sequencer with saturating payout.
// Rev 1.0 -- optional jackpot pool enabled by SLOT_CREDIT_JACKPOT_EN.
`timescale 1ns/1ps
`default_nettype none

module slot_credit_ctrl
  import slot_pkg::*;
#(
  parameter int unsigned CREDIT_W = DEF_CREDIT_W,
  parameter int unsigned LOAD_W   = DEF_LOAD_W,
  parameter int unsigned BET_W    = DEF_BET_W,
  parameter int unsigned MULT_W   = DEF_MULT_W,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              resetn,
  slot_credit_ctrl_if.slave bus
);

  localparam int unsigned PROD_W = BET_W + MULT_W;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [BET_W-1:0]    bet_q, bet_d;
  logic [MULT_W-1:0]   mult_q, mult_d;
  logic                tout_q, tout_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [CREDIT_W:0]   payout_q, payout_d;
  logic                round_done_q, round_done_d;
  logic                err_bet_q, err_bet_d;

  logic                bet_legal;
  logic [PROD_W-1:0]   prod;
  logic [CREDIT_W:0]   prod_ext;
  logic [CREDIT_W:0]   settle_amt;
  logic [CREDIT_W:0]   settle_pay;
  logic [CREDIT_W:0]   add_b;
  logic [CREDIT_W-1:0] credit_sum;

  assign bet_legal = (bus.bet != '0) && (CREDIT_W'(bus.bet) <= credit_q);
  assign prod      = PROD_W'(bet_q) * PROD_W'(mult_q);
  assign prod_ext  = (CREDIT_W+1)'(prod);

  // One credit adder serves both coin loads (IDLE) and settlement (SETTLE).
  assign add_b = (state_q == SETTLE) ? settle_amt : (CREDIT_W+1)'(bus.load_value);

  sat_adder #(
    .IN_W  (CREDIT_W + 1),
    .OUT_W (CREDIT_W)
  ) u_credit_add (
    .a_i   ({1'b0, credit_q}),
    .b_i   (add_b),
    .sum_o (credit_sum)
  );

`ifdef SLOT_CREDIT_JACKPOT_EN
  logic [CREDIT_W-1:0] pool_q, pool_d, pool_sum;
  logic [CREDIT_W:0]   jack_sum;
  logic                jack_win;

  // A timeout refund forces mult_q to 1, so it must never count as a jackpot hit.
  assign jack_win = (mult_q == '1) && !tout_q;

  sat_adder #(
    .IN_W  (CREDIT_W),
    .OUT_W (CREDIT_W)
  ) u_pool_add (
    .a_i   (pool_q),
    .b_i   (CREDIT_W'(bet_q)),
    .sum_o (pool_sum)
  );

  sat_adder #(
    .IN_W  (CREDIT_W + 1),
    .OUT_W (CREDIT_W + 1)
  ) u_jack_add (
    .a_i   (prod_ext),
    .b_i   ({1'b0, pool_q}),
    .sum_o (jack_sum)
  );

  assign settle_amt  = jack_win ? jack_sum : prod_ext;
  assign settle_pay  = jack_win ? jack_sum : {tout_q, prod_ext[CREDIT_W-1:0]};
  assign bus.jackpot = pool_q;

  always_comb begin
    pool_d = pool_q;
    if (state_q == SETTLE) begin
      if (mult_q == '0) pool_d = pool_sum;
      else if (jack_win) pool_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pool_q <= '0;
    else         pool_q <= pool_d;
  end
`else
  assign settle_amt = prod_ext;
  assign settle_pay = {tout_q, prod_ext[CREDIT_W-1:0]};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      bet_q        <= '0;
      mult_q       <= '0;
      tout_q       <= 1'b0;
      tmr_q        <= '0;
      payout_q     <= '0;
      round_done_q <= 1'b0;
      err_bet_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      bet_q        <= bet_d;
      mult_q       <= mult_d;
      tout_q       <= tout_d;
      tmr_q        <= tmr_d;
      payout_q     <= payout_d;
      round_done_q <= round_done_d;
      err_bet_q    <= err_bet_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!bus.load_en && bus.start && bet_legal) state_d = SPIN;
      SPIN:    if (bus.spin_done || (tmr_q == TMR_LAST))  state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d     = credit_q;
    bet_d        = bet_q;
    mult_d       = mult_q;
    tout_d       = tout_q;
    tmr_d        = tmr_q;
    payout_d     = payout_q;
    round_done_d = 1'b0;
    err_bet_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_d  = '0;
        tout_d = 1'b0;
        if (bus.load_en) begin
          credit_d = credit_sum;
        end else if (bus.start) begin
          if (bet_legal) begin
            credit_d = credit_q - CREDIT_W'(bus.bet);
            bet_d    = bus.bet;
          end else begin
            err_bet_d = 1'b1;
          end
        end
      end
      SPIN: begin
        tmr_d = tmr_q + 1'b1;
        if (bus.spin_done) begin
          mult_d = bus.win_mult;
        end else if (tmr_q == TMR_LAST) begin
          mult_d = MULT_W'(1);
          tout_d = 1'b1;
        end
      end
      SETTLE: begin
        credit_d     = credit_sum;
        payout_d     = settle_pay;
        round_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.spin_req   = (state_q == SPIN);
  assign bus.busy       = (state_q != IDLE);
  assign bus.credit     = credit_q;
  assign bus.payout     = payout_q;
  assign bus.round_done = round_done_q;
  assign bus.err_bet    = err_bet_q;

endmodule

`default_nettype wire

// File: tb/tb_slot_credit_ctrl.sv
// tb_slot_credit_ctrl: directed plus randomized rounds against an arithmetic ledger model.
// Rev 1.0 -- jackpot scenarios compiled in with SLOT_CREDIT_JACKPOT_EN.
`timescale 1ns/1ps
`default_nettype none

module tb_slot_credit_ctrl;

  localparam int unsigned CW   = 8;
  localparam int unsigned LW   = 5;
  localparam int unsigned BW   = 3;
  localparam int unsigned MW   = 2;
  localparam int unsigned TO   = 16;
  localparam int          CMAX = 255;

  logic clk = 1'b0;
  logic resetn;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int          exp_credit;
  int          exp_pool;

  slot_credit_ctrl_if #(.CREDIT_W(CW), .LOAD_W(LW), .BET_W(BW), .MULT_W(MW)) bus ();

  slot_credit_ctrl #(
    .CREDIT_W (CW),
    .LOAD_W   (LW),
    .BET_W    (BW),
    .MULT_W   (MW),
    .TIMEOUT  (TO)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_en    = 1'b0;
    bus.load_value = '0;
    bus.start      = 1'b0;
    bus.bet        = '0;
    bus.spin_done  = 1'b0;
    bus.win_mult   = '0;
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_credit"},  32'(bus.credit),     0);
    chk({tag, "_busy"},    32'(bus.busy),       0);
    chk({tag, "_spinreq"}, 32'(bus.spin_req),   0);
    chk({tag, "_rdone"},   32'(bus.round_done), 0);
    chk({tag, "_errbet"},  32'(bus.err_bet),    0);
    chk({tag, "_payout"},  32'(bus.payout),     0);
`ifdef SLOT_CREDIT_JACKPOT_EN
    chk({tag, "_jackpot"}, 32'(bus.jackpot),    0);
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    exp_credit = 0;
    exp_pool   = 0;
    chk_zero("reset");
  endtask

  task automatic do_load(input int v, input bit with_start);
    bus.load_en    = 1'b1;
    bus.load_value = LW'(v);
    bus.start      = with_start;
    bus.bet        = BW'(1);
    tick();
    idle_inputs();
    exp_credit = sat(exp_credit + v);
    chk("load_credit", 32'(bus.credit),  32'(exp_credit));
    chk("load_busy",   32'(bus.busy),    0);
    chk("load_errbet", 32'(bus.err_bet), 0);
  endtask

  task automatic do_reject(input int b);
    bus.start = 1'b1;
    bus.bet   = BW'(b);
    tick();
    idle_inputs();
    chk("rej_errbet",  32'(bus.err_bet),  1);
    chk("rej_credit",  32'(bus.credit),   32'(exp_credit));
    chk("rej_busy",    32'(bus.busy),     0);
    tick();
    chk("rej_pulse",   32'(bus.err_bet),  0);
    chk("rej_spinreq", 32'(bus.spin_req), 0);
  endtask

  // Enters with the DUT in its first SPIN cycle; returns in the IDLE cycle showing round_done.
  task automatic spin_phase(input int b, input int lat, input int m);
    bit timed_out = 1'b0;
    int em;
    int prod;
    int pay;
    for (int k = 0; k < int'(TO); k++) begin
      if (k == lat) begin
        bus.spin_done = 1'b1;
        bus.win_mult  = MW'(m);
        tick();
        bus.spin_done = 1'b0;
        bus.win_mult  = '0;
        break;
      end
      bus.load_en    = 1'($urandom_range(0, 1));
      bus.load_value = LW'($urandom);
      tick();
      bus.load_en = 1'b0;
      if (k == int'(TO) - 1) timed_out = 1'b1;
    end
    chk("settle_busy",    32'(bus.busy),       1);
    chk("settle_rdone",   32'(bus.round_done), 0);
    chk("settle_spinreq", 32'(bus.spin_req),   0);
    chk("settle_credit",  32'(bus.credit),     32'(exp_credit));

    em   = timed_out ? 1 : m;
    prod = b * em;
`ifdef SLOT_CREDIT_JACKPOT_EN
    if (!timed_out && m == 0) begin
      exp_pool = sat(exp_pool + b);
      pay      = prod;
    end else if (!timed_out && m == 3) begin
      pay        = prod + exp_pool;
      exp_pool   = 0;
      exp_credit = sat(exp_credit + pay);
    end else begin
      pay        = (timed_out ? 256 : 0) + prod;
      exp_credit = sat(exp_credit + prod);
    end
`else
    pay        = (timed_out ? 256 : 0) + prod;
    exp_credit = sat(exp_credit + prod);
`endif
    tick();
    chk("done_rdone",  32'(bus.round_done), 1);
    chk("done_credit", 32'(bus.credit),     32'(exp_credit));
    chk("done_payout", 32'(bus.payout),     32'(pay));
    chk("done_busy",   32'(bus.busy),       0);
`ifdef SLOT_CREDIT_JACKPOT_EN
    chk("done_jackpot", 32'(bus.jackpot),   32'(exp_pool));
`endif
  endtask

  task automatic do_round(input int b, input int lat, input int m, input bit hold);
    bus.start = 1'b1;
    bus.bet   = BW'(b);
    tick();
    if (!hold) bus.start = 1'b0;
    exp_credit -= b;
    chk("start_credit",  32'(bus.credit),   32'(exp_credit));
    chk("start_spinreq", 32'(bus.spin_req), 1);
    chk("start_busy",    32'(bus.busy),     1);
    spin_phase(b, lat, m);
    if (hold) begin
      tick();
      exp_credit -= b;
      chk("retrig_busy",   32'(bus.busy),   1);
      chk("retrig_credit", 32'(bus.credit), 32'(exp_credit));
      bus.start = 1'b0;
      spin_phase(b, 0, 1);
    end
    tick();
    chk("after_rdone", 32'(bus.round_done), 0);
  endtask

  initial begin
    int op;
    int b;
    int lat;
    int lim;

    idle_inputs();
    do_reset();

    do_load(20, 1'b1);
    do_round(3, 0, 2, 1'b0);

    do_reset();
    do_load(2, 1'b0);
    do_reject(3);
    do_reject(0);

    bus.spin_done = 1'b1;
    bus.win_mult  = MW'(3);
    tick();
    idle_inputs();
    chk("stray_done_credit", 32'(bus.credit), 2);
    chk("stray_done_busy",   32'(bus.busy),   0);
    tick();
    chk("stray_done_rdone",  32'(bus.round_done), 0);

    do_reset();
    for (int i = 0; i < 8; i++) do_load(31, 1'b0);
    do_load(2, 1'b0);
    do_round(7, 0, 3, 1'b0);
    chk("saturate_255", 32'(bus.credit), 255);

    do_round(4, int'(TO) + 5, 1, 1'b0);
    do_round(2, 1, 1, 1'b1);
    do_round(1, 3, 0, 1'b0);

`ifdef SLOT_CREDIT_JACKPOT_EN
    do_reset();
    do_load(30, 1'b0);
    do_round(5, 0, 0, 1'b0);
    do_round(5, 1, 0, 1'b0);
    chk("jackpot_pool10", 32'(bus.jackpot), 10);
    do_round(1, 0, 3, 1'b0);
    chk("jackpot_credit", 32'(bus.credit),  32);
    chk("jackpot_empty",  32'(bus.jackpot), 0);
`endif

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 9));
      if (op < 3 || exp_credit == 0) begin
        do_load(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end else if (op < 4) begin
        if (exp_credit < 7) do_reject(int'($urandom_range(exp_credit + 1, 7)));
        else                do_reject(0);
      end else begin
        lim = (exp_credit < 7) ? exp_credit : 7;
        b   = int'($urandom_range(1, lim));
        lat = ($urandom_range(0, 9) == 0) ? int'(TO) + 2 : int'($urandom_range(0, 4));
        do_round(b, lat, int'($urandom_range(0, 3)), 1'b0);
      end
    end

    do_load(10, 1'b0);
    bus.start = 1'b1;
    bus.bet   = BW'(3);
    tick();
    bus.start = 1'b0;
    tick();
    chk("midspin_busy", 32'(bus.busy), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk_zero("async_reset");
    tick();
    resetn = 1'b1;
    exp_credit = 0;
    tick();
    chk("post_reset_credit", 32'(bus.credit), 0);
    chk("post_reset_busy",   32'(bus.busy),   0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
